// File: rtl/instr_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage_if
// Description : Instruction-memory read bus between the fetch stage (master)
//               and instruction memory (slave): req/addr out, ack/data back.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_stage_if;
  logic       imem_req;
  logic [9:0] imem_addr;
  logic       imem_ack;
  logic [9:0] imem_data;

  // Fetch stage drives the request; memory answers with ack/data.
  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage
// Description : Requests the instruction at the current PC over a req/ack bus,
//               holds it in a single-entry IR for decode, feeds PC-advance and
//               branch redirect back to the fetch unit, stops on HALT.
//               Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_stage #(
  parameter logic [3:0]  JMP_OPC  = 4'b1111,
  parameter logic [3:0]  BRZ_OPC  = 4'b1110,
  parameter logic [3:0]  HALT_OPC = 4'b0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic [9:0]            pc,
  input  wire logic                  zero_flag,
  input  wire logic                  stall,
  instr_fetch_stage_if.master        imem,
  output logic                       pc_en,
  output logic                       br_ctrl,
  output logic [9:0]                 br_addr,
  output logic [9:0]                 ir,
  output logic [9:0]                 ir_pc,
  output logic                       ir_valid,
  output logic                       halted,
  output logic                       fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_FULL   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] addr_q, addr_d;
  logic [9:0] ir_q, ir_d;
  logic [9:0] ir_pc_q, ir_pc_d;
  logic       ir_valid_q, ir_valid_d;
  logic [9:0] br_addr_q, br_addr_d;

  logic       ack_cycle;
  logic       taken;
  logic       is_halt;
  logic [9:0] br_target;
  logic       timeout;

  // Ack is only meaningful while a request is outstanding.
  assign ack_cycle = (state_q == S_FETCH) && imem.imem_ack;
  assign taken     = (imem.imem_data[9:6] == JMP_OPC) ||
                     ((imem.imem_data[9:6] == BRZ_OPC) && zero_flag);
  assign is_halt   = (imem.imem_data[9:6] == HALT_OPC) && (imem.imem_data[5:0] == 6'd0);
  // Page bits come from the fetched address, not from the advanced PC.
  assign br_target = {addr_q[9:6], imem.imem_data[5:0]};

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wd_q, wd_d;
  logic       fetch_err_q, fetch_err_d;

  assign timeout = (state_q == S_FETCH) && !imem.imem_ack && (wd_q == 4'(TIMEOUT - 1));

  // Watchdog: clear on entry to FETCH, count ack-less FETCH cycles, sticky error.
  always_comb begin
    wd_d        = wd_q;
    fetch_err_d = fetch_err_q;
    if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
      wd_d = 4'd0;
    end else if ((state_q == S_FETCH) && !imem.imem_ack) begin
      wd_d = wd_q + 4'd1;
    end
    if (timeout) begin
      fetch_err_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q        <= 4'd0;
      fetch_err_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout        = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    br_addr_d  = br_addr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        addr_d  = pc;
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          ir_d       = imem.imem_data;
          ir_pc_d    = addr_q;
          ir_valid_d = 1'b1;
          br_addr_d  = br_target;
          state_d    = is_halt ? S_HALTED : S_FULL;
        end else if (timeout) begin
          state_d = S_HALTED;
        end
      end
      S_FULL: begin
        // No flush on a taken branch: the redirected pc is what gets latched here.
        if (!stall) begin
          ir_valid_d = 1'b0;
          addr_d     = pc;
          state_d    = S_FETCH;
        end
      end
      S_HALTED: begin
        if (!stall) begin
          ir_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= 10'd0;
      ir_q       <= 10'd0;
      ir_pc_q    <= 10'd0;
      ir_valid_q <= 1'b0;
      br_addr_q  <= 10'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      br_addr_q  <= br_addr_d;
    end
  end

  // Outputs decode from state so reset silences them without a clock edge.
  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = addr_q;
  assign pc_en          = ack_cycle;
  assign br_ctrl        = ack_cycle && taken;
  assign br_addr        = ack_cycle ? br_target : br_addr_q;
  assign ir             = ir_q;
  assign ir_pc          = ir_pc_q;
  assign ir_valid       = ir_valid_q;
  assign halted         = (state_q == S_HALTED);

endmodule
`default_nettype wire
